legv8_fetch_control: RTL and testbench
======================================

# legv8_fetch_control

Multi-cycle fetch/decode/control sequencer sitting directly upstream of the LEGv8 register-file/ALU/data-memory datapath. It holds the PC, fetches 32-bit instructions over a request/valid handshake, latches them in an instruction register, slices the register and immediate fields, and drives the datapath control strobes one phase at a time. It consumes the datapath `Zero` flag to resolve CBZ.

## Interface
- `RESET_PC`, 64'h0: PC value loaded on reset.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `run` in 1: permits issue of a new fetch.
- `imem_req` out 1: fetch request.
- `imem_addr` out 64: fetch address, always equal to `pc`.
- `imem_valid` in 1: instruction-memory data valid.
- `imem_rdata` in 32: fetched instruction.
- `zero` in 1: datapath ALU Zero flag.
- `Read1`, `Read2`, `WriteReg` out 6 each: register addresses; 5-bit fields are zero-extended.
- `SEin` out 9: D-format address field, IR[20:12].
- `OpCodefield` out 11: IR[31:21].
- `ALUOp` out 2; `AluSrc`, `memtoReg`, `MemRead`, `MemWrite`, `RegWrite` out 1 each: datapath controls.
- `pc` out 64: current PC.
- `halted` out 1: illegal opcode seen.

## Operation
- **States:** FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT.
- **FETCH**
  - `imem_req` = `run`.
  - IR loads `imem_rdata` on the edge where `imem_req` and `imem_valid` are both 1, then the FSM moves to DECODE.
  - `imem_valid` is ignored while `imem_req` = 0.
- **DECODE:** fields are registered from IR and held until the next IR load.
  - `Read1` = Rn = IR[9:5].
  - `WriteReg` = Rd/Rt = IR[4:0].
  - `Read2` = Rm = IR[20:16] for R-format; Rt = IR[4:0] for STUR and CBZ.
- **Control words**
  - R-format (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000): ALUOp=10, AluSrc=0, memtoReg=1.
  - LDUR 11111000010: ALUOp=00, AluSrc=1, memtoReg=0.
  - STUR 11111000000: ALUOp=00, AluSrc=1.
  - CBZ (IR[31:24]=10110100): ALUOp=01, AluSrc=0.
  - B (IR[31:26]=000101): no datapath use.
- **memtoReg:** 1 selects the ALU result; 0 selects memory read data.
- **State sequences**
  - R-format: DECODE→EXECUTE→WRITEBACK.
  - LDUR: DECODE→EXECUTE→MEMORY→WRITEBACK.
  - STUR: DECODE→EXECUTE→MEMORY.
  - CBZ and B: DECODE→EXECUTE.
  - Last state of every sequence → FETCH.
- **Strobes**
  - `MemRead` = 1 in MEMORY and WRITEBACK of LDUR.
  - `MemWrite` = 1 for exactly the MEMORY cycle of STUR.
  - `RegWrite` = 1 for exactly the WRITEBACK cycle of R-format and LDUR.
  - All strobes are 0 in FETCH, DECODE and HALT.
- **PC update** (64-bit, wrap-around modulo 2^64, no overflow flag), on leaving the last state of an instruction:
  - Taken branch: `pc` ← `pc` + (sign-extended immediate << 2).
  - Otherwise: `pc` ← `pc` + 4.
  - CBZ immediate is IR[23:5] (19 bits). B immediate is IR[25:0] (26 bits).
- **CBZ resolution:** taken iff `zero` = 1, sampled in EXECUTE.
- **Illegal opcode:** DECODE→HALT. `halted` = 1, `pc` is frozen, and the FSM stays in HALT until reset.
- **`run` deassertion:** the current instruction completes; the FSM then idles in FETCH with `imem_req` = 0.

## Timing
- **Reset:** on `reset_n` low, immediately and asynchronously:
  - `pc` = `imem_addr` = `RESET_PC`; state = FETCH.
  - All other outputs = 0.
  - Any in-flight strobe is cleared the same instant; no write completes after reset assertion.
- **Cycles per instruction** with zero-wait memory (`imem_valid` high in the first request cycle):
  - R-format 4, LDUR 5, STUR 4, CBZ/B 3.
  - Each wait cycle adds 1.
- **Field outputs:** stable from the first DECODE cycle through the final state of the instruction.

## Configuration
- `LEGV8_BRANCH_EN` defined: CBZ and B are decoded and executed as above.
- `LEGV8_BRANCH_EN` undefined: CBZ and B encodings are illegal and go to HALT. The `zero` input is unused.

## Structure
- Shared package `legv8_ctrl_pkg` holds:
  - state enum;
  - opcode constants (11-, 8- and 6-bit);
  - ALUOp encodings (00 load/store, 01 pass-B/CBZ, 10 R-type);
  - a control-word struct.
- One combinational sub-module, `legv8_main_decoder`: IR[31:21] → control word plus legal and instruction-class flags.

## Test plan
- Reset with `RESET_PC`=0x100, then `reset_n` high, `run`=1 → `imem_addr`=0x100, `imem_req`=1; all strobes 0.
- ADD X3,X1,X2 (0x8B020023), zero-wait memory:
  - `Read1`=1, `Read2`=2, `WriteReg`=3, ALUOp=10, `memtoReg`=1.
  - `RegWrite` high exactly in cycle 4; `pc` → 0x104.
- LDUR X5,[X2,#8] (0xF8408045):
  - `SEin`=8, AluSrc=1.
  - `MemRead` high in cycles 4–5, `RegWrite` only in cycle 5, `memtoReg`=0.
- STUR with `imem_valid` delayed 2 cycles → `MemWrite` single pulse in cycle 6, `RegWrite` never asserted.
- CBZ X4,#+3 at `pc`=0x200:
  - `zero`=1 → next `imem_addr`=0x20C.
  - `zero`=0 → 0x204.
  - With macro undefined → `halted`=1, `pc` holds 0x200.
- Mid-sequence:
  - `reset_n` pulsed low during LDUR MEMORY → strobes drop immediately, `pc`=`RESET_PC`.
  - Opcode 0xFFFFFFFF → `halted`=1 and no further `imem_req`.

Source files
------------

// File: rtl/legv8_ctrl_pkg.sv
// Shared types and constants for the LEGv8 multi-cycle fetch/control sequencer:
// FSM states, opcode encodings, ALUOp codes and the decoded control word.
package legv8_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE  = 3'd0,
    CLS_RTYPE = 3'd1,
    CLS_LDUR  = 3'd2,
    CLS_STUR  = 3'd3,
    CLS_CBZ   = 3'd4,
    CLS_B     = 3'd5
  } instr_cls_e;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  localparam logic [1:0] ALUOP_LDST  = 2'b00;
  localparam logic [1:0] ALUOP_CBZ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_to_reg;
  } ctrl_word_t;

endpackage

// File: rtl/legv8_main_decoder.sv
// Combinational main decoder: IR[31:21] -> control word, legal flag and class.
// CBZ and B are only recognised when LEGV8_BRANCH_EN is defined.
module legv8_main_decoder
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output ctrl_word_t  ctrl,
  output logic        legal,
  output instr_cls_e  cls
);

  always_comb begin
    ctrl  = '0;
    legal = 1'b0;
    cls   = CLS_NONE;
    if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND || opcode == OP_ORR) begin
      ctrl  = '{alu_op: ALUOP_RTYPE, alu_src: 1'b0, mem_to_reg: 1'b1};
      legal = 1'b1;
      cls   = CLS_RTYPE;
    end else if (opcode == OP_LDUR) begin
      ctrl  = '{alu_op: ALUOP_LDST, alu_src: 1'b1, mem_to_reg: 1'b0};
      legal = 1'b1;
      cls   = CLS_LDUR;
    end else if (opcode == OP_STUR) begin
      ctrl  = '{alu_op: ALUOP_LDST, alu_src: 1'b1, mem_to_reg: 1'b0};
      legal = 1'b1;
      cls   = CLS_STUR;
`ifdef LEGV8_BRANCH_EN
    end else if (opcode[10:3] == OP_CBZ) begin
      ctrl  = '{alu_op: ALUOP_CBZ, alu_src: 1'b0, mem_to_reg: 1'b0};
      legal = 1'b1;
      cls   = CLS_CBZ;
    end else if (opcode[10:5] == OP_B) begin
      legal = 1'b1;
      cls   = CLS_B;
`endif
    end
  end

endmodule

// File: rtl/legv8_fetch_control.sv
// LEGv8 multi-cycle fetch/decode/control sequencer. Branch support (CBZ, B)
// is compiled in with LEGV8_BRANCH_EN; otherwise those encodings halt.
module legv8_fetch_control
  import legv8_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        run,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        zero,
  output logic [5:0]  Read1,
  output logic [5:0]  Read2,
  output logic [5:0]  WriteReg,
  output logic [8:0]  SEin,
  output logic [10:0] OpCodefield,
  output logic [1:0]  ALUOp,
  output logic        AluSrc,
  output logic        memtoReg,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic [63:0] pc,
  output logic        halted,
  output logic [2:0]  state_dbg
);

  // Handshake: an instruction is accepted on a rising edge where imem_req and
  // imem_valid are both 1; imem_valid is ignored whenever imem_req is 0.
  state_e     state_q, state_d;
  instr_cls_e cls_q, cls_d, dec_cls;
  ctrl_word_t ctrl_q, ctrl_d, dec_ctrl;
  logic       dec_legal, legal_q, legal_d;
  logic [63:0] pc_q, pc_d, pc_inc;
  logic        halted_q, halted_d;
  logic [5:0]  read1_q, read1_d, read2_q, read2_d, write_reg_q, write_reg_d;
  logic [8:0]  sein_q, sein_d;
  logic [10:0] opc_q, opc_d;
  logic        mem_read_q, mem_read_d, mem_write_q, mem_write_d, reg_write_q, reg_write_d;
`ifdef LEGV8_BRANCH_EN
  logic [63:0] off_q, off_d;
`else
  logic [2:0]  unused_bits;
  assign unused_bits = {zero, imem_rdata[11:10]};
`endif

  legv8_main_decoder u_dec (
    .opcode (imem_rdata[31:21]),
    .ctrl   (dec_ctrl),
    .legal  (dec_legal),
    .cls    (dec_cls)
  );

  assign pc_inc = pc_q + 64'd4;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    halted_d    = halted_q;
    read1_d     = read1_q;
    read2_d     = read2_q;
    write_reg_d = write_reg_q;
    sein_d      = sein_q;
    opc_d       = opc_q;
    ctrl_d      = ctrl_q;
    cls_d       = cls_q;
    legal_d     = legal_q;
`ifdef LEGV8_BRANCH_EN
    off_d       = off_q;
`endif
    case (state_q)
      S_FETCH: begin
        if (run && imem_valid) begin
          state_d     = S_DECODE;
          opc_d       = imem_rdata[31:21];
          read1_d     = {1'b0, imem_rdata[9:5]};
          write_reg_d = {1'b0, imem_rdata[4:0]};
          read2_d     = (dec_cls == CLS_STUR || dec_cls == CLS_CBZ) ?
                        {1'b0, imem_rdata[4:0]} : {1'b0, imem_rdata[20:16]};
          sein_d      = imem_rdata[20:12];
          ctrl_d      = dec_ctrl;
          cls_d       = dec_cls;
          legal_d     = dec_legal;
`ifdef LEGV8_BRANCH_EN
          // Branch offset is pre-scaled by 4 so EXECUTE only needs one adder.
          off_d = (dec_cls == CLS_CBZ) ? {{43{imem_rdata[23]}}, imem_rdata[23:5], 2'b00}
                                       : {{36{imem_rdata[25]}}, imem_rdata[25:0], 2'b00};
`endif
        end
      end
      S_DECODE: begin
        if (!legal_q) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        case (cls_q)
          CLS_RTYPE:          state_d = S_WRITEBACK;
          CLS_LDUR, CLS_STUR: state_d = S_MEMORY;
`ifdef LEGV8_BRANCH_EN
          CLS_CBZ: begin
            state_d = S_FETCH;
            pc_d    = zero ? pc_q + off_q : pc_inc;
          end
          CLS_B: begin
            state_d = S_FETCH;
            pc_d    = pc_q + off_q;
          end
`endif
          default: begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end
        endcase
      end
      S_MEMORY: begin
        if (cls_q == CLS_LDUR) begin
          state_d = S_WRITEBACK;
        end else begin
          state_d = S_FETCH;
          pc_d    = pc_inc;
        end
      end
      S_WRITEBACK: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
      end
      default: state_d = S_HALT;
    endcase
    // Strobes are registered against the next state so they line up with it.
    mem_read_d  = (cls_q == CLS_LDUR) && (state_d == S_MEMORY || state_d == S_WRITEBACK);
    mem_write_d = (cls_q == CLS_STUR) && (state_d == S_MEMORY);
    reg_write_d = (state_d == S_WRITEBACK);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      halted_q    <= 1'b0;
      read1_q     <= '0;
      read2_q     <= '0;
      write_reg_q <= '0;
      sein_q      <= '0;
      opc_q       <= '0;
      ctrl_q      <= '0;
      cls_q       <= CLS_NONE;
      legal_q     <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
`ifdef LEGV8_BRANCH_EN
      off_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      halted_q    <= halted_d;
      read1_q     <= read1_d;
      read2_q     <= read2_d;
      write_reg_q <= write_reg_d;
      sein_q      <= sein_d;
      opc_q       <= opc_d;
      ctrl_q      <= ctrl_d;
      cls_q       <= cls_d;
      legal_q     <= legal_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      reg_write_q <= reg_write_d;
`ifdef LEGV8_BRANCH_EN
      off_q       <= off_d;
`endif
    end
  end

  assign imem_req    = run && (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign halted      = halted_q;
  assign Read1       = read1_q;
  assign Read2       = read2_q;
  assign WriteReg    = write_reg_q;
  assign SEin        = sein_q;
  assign OpCodefield = opc_q;
  assign ALUOp       = ctrl_q.alu_op;
  assign AluSrc      = ctrl_q.alu_src;
  assign memtoReg    = ctrl_q.mem_to_reg;
  assign MemRead     = mem_read_q;
  assign MemWrite    = mem_write_q;
  assign RegWrite    = reg_write_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_legv8_fetch_control.sv
// Directed table-driven bench for legv8_fetch_control (RESET_PC = 0x100),
// plus hand-written reset/halt sequences.
module tb_legv8_fetch_control;
  import legv8_ctrl_pkg::*;

  logic        clock, reset_n, run, imem_req, imem_valid, zero;
  logic [63:0] imem_addr, pc;
  logic [31:0] imem_rdata;
  logic [5:0]  Read1, Read2, WriteReg;
  logic [8:0]  SEin;
  logic [10:0] OpCodefield;
  logic [1:0]  ALUOp;
  logic        AluSrc, memtoReg, MemRead, MemWrite, RegWrite, halted;
  logic [2:0]  state_dbg;

  legv8_fetch_control #(.RESET_PC(64'h100)) dut (
    .clock(clock), .reset_n(reset_n), .run(run), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .zero(zero), .Read1(Read1), .Read2(Read2), .WriteReg(WriteReg), .SEin(SEin),
    .OpCodefield(OpCodefield), .ALUOp(ALUOp), .AluSrc(AluSrc), .memtoReg(memtoReg),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .pc(pc),
    .halted(halted), .state_dbg(state_dbg)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    int          waits;
    logic        chk_fields;
    logic [5:0]  r1, r2, wr;
    logic [8:0]  sein;
    logic [1:0]  aluop;
    logic        alusrc, m2r;
    int          cycles;
    logic [15:0] mr, mw, rw;
    logic [63:0] exp_pc;
    logic        exp_halt;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] pc_model;
  int          n_cmp = 0;
  int          n_fail = 0;

  // scoreboard compare
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input logic z, input int waits,
                              input logic chk, input logic [5:0] r1, input logic [5:0] r2,
                              input logic [5:0] wr, input logic [8:0] se, input logic [1:0] aop,
                              input logic asrc, input logic m2r, input int cyc,
                              input logic [15:0] mr, input logic [15:0] mw, input logic [15:0] rw,
                              input logic [63:0] epc, input logic eh);
    vec_t v;
    v.instr = instr; v.zero = z; v.waits = waits; v.chk_fields = chk;
    v.r1 = r1; v.r2 = r2; v.wr = wr; v.sein = se; v.aluop = aop; v.alusrc = asrc; v.m2r = m2r;
    v.cycles = cyc; v.mr = mr; v.mw = mw; v.rw = rw; v.exp_pc = epc; v.exp_halt = eh;
    return v;
  endfunction

  // driver: one instruction, monitored cycle by cycle (cycle 1 = first FETCH cycle)
  task automatic run_row(input int idx, input vec_t v);
    logic [63:0] pc0;
    int          ret;
    logic [15:0] mr, mw, rw;
    logic        stable;
    logic [5:0]  r1, r2, wr;
    logic [8:0]  se;
    logic [1:0]  aop;
    logic        asrc, m2r;
    string       p;
    p = $sformatf("row%0d_", idx);
    pc0 = pc_model; ret = 0; mr = '0; mw = '0; rw = '0; stable = 1'b1;
    r1 = '0; r2 = '0; wr = '0; se = '0; aop = '0; asrc = 1'b0; m2r = 1'b0;
    imem_rdata = v.instr;
    zero = v.zero;
    imem_valid = (v.waits == 0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      if (c == 1) check({p, "fetch_addr"}, imem_addr, pc0);
      if (c > v.waits + 1 && imem_req) begin
        ret = c - 1;
        break;
      end
      if (MemRead)  mr[c] = 1'b1;
      if (MemWrite) mw[c] = 1'b1;
      if (RegWrite) rw[c] = 1'b1;
      if (c == v.waits + 2) begin
        r1 = Read1; r2 = Read2; wr = WriteReg; se = SEin; aop = ALUOp; asrc = AluSrc; m2r = memtoReg;
      end else if (c > v.waits + 2 &&
                   {Read1, Read2, WriteReg, SEin, ALUOp, AluSrc, memtoReg} !== {r1, r2, wr, se, aop, asrc, m2r}) begin
        stable = 1'b0;
      end
      @(posedge clock);
      #1;
      imem_valid = (c + 1 == v.waits + 1);
    end
    imem_valid = 1'b0;
    check({p, "cycles"}, ret, v.cycles);
    check({p, "next_pc"}, pc, v.exp_pc);
    check({p, "halted"}, halted, v.exp_halt);
    check({p, "memread_cycles"}, mr, v.mr);
    check({p, "memwrite_cycles"}, mw, v.mw);
    check({p, "regwrite_cycles"}, rw, v.rw);
    if (v.chk_fields) begin
      check({p, "read1"}, r1, v.r1);
      check({p, "read2"}, r2, v.r2);
      check({p, "writereg"}, wr, v.wr);
      check({p, "sein"}, se, v.sein);
      check({p, "aluop"}, aop, v.aluop);
      check({p, "alusrc"}, asrc, v.alusrc);
      check({p, "memtoreg"}, m2r, v.m2r);
      check({p, "fields_stable"}, stable, 1'b1);
    end
    pc_model = v.exp_pc;
    if (ret != 0) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    reset_n = 1'b0; run = 1'b0; imem_valid = 1'b0; imem_rdata = '0; zero = 1'b0;

    // Vector table: instr, zero, waits, chk, Read1, Read2, WriteReg, SEin, ALUOp, AluSrc,
    // memtoReg, cycles, MemRead/MemWrite/RegWrite cycle masks, next pc, halted.
    vecs.push_back(mk(32'h8B020023, 0, 0, 1, 1, 2, 3, 9'h020, 2'b10, 0, 1, 4, 16'h0, 16'h0, 16'h0010, 64'h104, 0));
    vecs.push_back(mk(32'hF8408045, 0, 0, 1, 2, 0, 5, 9'h008, 2'b00, 1, 0, 5, 16'h0030, 16'h0, 16'h0020, 64'h108, 0));
    vecs.push_back(mk(32'hF8010067, 0, 2, 1, 3, 7, 7, 9'h010, 2'b00, 1, 0, 6, 16'h0, 16'h0040, 16'h0, 64'h10C, 0));
    vecs.push_back(mk(32'hCB0B0149, 0, 1, 1, 10, 11, 9, 9'h0B0, 2'b10, 0, 1, 5, 16'h0, 16'h0, 16'h0020, 64'h110, 0));
    vecs.push_back(mk(32'h8A030041, 0, 0, 1, 2, 3, 1, 9'h030, 2'b10, 0, 1, 4, 16'h0, 16'h0, 16'h0010, 64'h114, 0));
    vecs.push_back(mk(32'hAA1D03DF, 0, 0, 1, 30, 29, 31, 9'h1D0, 2'b10, 0, 1, 4, 16'h0, 16'h0, 16'h0010, 64'h118, 0));
    for (int i = 0; i < 58; i++)
      vecs.push_back(mk(32'h8B020023, 0, 0, 1, 1, 2, 3, 9'h020, 2'b10, 0, 1, 4, 16'h0, 16'h0, 16'h0010,
                        64'h118 + 64'(4 * (i + 1)), 0));
`ifdef LEGV8_BRANCH_EN
    vecs.push_back(mk(32'hB4000064, 1, 0, 1, 3, 4, 4, 9'h000, 2'b01, 0, 0, 3, 16'h0, 16'h0, 16'h0, 64'h20C, 0));
    vecs.push_back(mk(32'hB4000064, 0, 0, 1, 3, 4, 4, 9'h000, 2'b01, 0, 0, 3, 16'h0, 16'h0, 16'h0, 64'h210, 0));
    vecs.push_back(mk(32'h17FFFFFC, 0, 0, 1, 31, 31, 28, 9'h1FF, 2'b00, 0, 0, 3, 16'h0, 16'h0, 16'h0, 64'h200, 0));
`else
    vecs.push_back(mk(32'hB4000064, 1, 0, 0, 0, 0, 0, 9'h0, 2'b00, 0, 0, 0, 16'h0, 16'h0, 16'h0, 64'h200, 1));
`endif

    // reset state
    #23;
    check("reset_pc", pc, 64'h100);
    check("reset_imem_addr", imem_addr, 64'h100);
    check("reset_state", state_dbg, S_FETCH);
    check("reset_strobes", {MemRead, MemWrite, RegWrite, imem_req}, 4'b0);
    check("reset_ctrl", {ALUOp, AluSrc, memtoReg, halted, Read1, Read2, WriteReg, SEin, OpCodefield}, '0);
    reset_n = 1'b1;
    #4;
    run = 1'b1;
    #1;
    check("post_reset_req", imem_req, 1'b1);
    check("post_reset_addr", imem_addr, 64'h100);
    pc_model = 64'h100;

    for (int i = 0; i < vecs.size(); i++) run_row(i, vecs[i]);

    // reset pulsed during LDUR MEMORY
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    imem_rdata = 32'hF8408045;
    imem_valid = 1'b1;
    @(posedge clock); #1;
    imem_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("ldur_mem_state", state_dbg, S_MEMORY);
    check("ldur_mem_read", MemRead, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_strobes", {MemRead, MemWrite, RegWrite}, 3'b0);
    check("async_rst_pc", pc, 64'h100);
    check("async_rst_state", state_dbg, S_FETCH);
    @(posedge clock); #1;
    check("rst_held_regwrite", RegWrite, 1'b0);
    reset_n = 1'b1;
    pc_model = 64'h100;

    // illegal opcode halts, pc frozen, no further requests
    run_row(100, mk(32'hFFFFFFFF, 0, 0, 1, 31, 31, 31, 9'h1FF, 2'b00, 0, 0, 0,
                    16'h0, 16'h0, 16'h0, 64'h100, 1));
    check("halt_no_req", imem_req, 1'b0);
    check("halt_state", state_dbg, S_HALT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
